up_down_count_checker: RTL and testbench

Synthesizable in-circuit checker that sits on the output side of the 4-bit `up_down_counter`. It samples the counter's `count`, together with the same `up_down_sw` and counter reset that drive it. From each sample it predicts the next value and flags any deviation. It also reports wrap-around events and latches a sticky fault after a programmable number of errors, for use in hardware self-test and on-board debug.

---
 rtl/up_down_count_checker.sv | 96 +++++++++
 tb/tb_up_down_count_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/up_down_count_checker.sv
// In-circuit checker for a modulo-2^WIDTH up/down counter. It predicts each
// count value from the previous sample and flags deviations, wraps and faults.
module up_down_count_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned FAULT_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_reset,
  input  logic             up_down_sw,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic             wrap_up,
  output logic             wrap_down,
  output logic [ERR_W-1:0] err_count,
  output logic             locked,
  output logic             fault
);

  typedef enum logic [1:0] {ST_INIT, ST_TRACK, ST_FAULT} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q;
  logic               sw_q, crst_q;
  logic [WIDTH-1:0]   expected_q, expected_d, pred;
  logic               mismatch_q, mismatch_d;
  logic               wrap_up_q, wrap_up_d;
  logic               wrap_down_q, wrap_down_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               locked_q, fault_q;
  logic               checking;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    checking    = (state_q != ST_INIT);
    pred        = crst_q ? '0 : (sw_q ? prev_q + WIDTH'(1) : prev_q - WIDTH'(1));
    expected_d  = checking ? pred : '0;
    // 4-state inequality so X/Z on the observed bus counts as an error in simulation
    mismatch_d  = checking && (count !== pred);
    wrap_up_d   = checking && !crst_q && sw_q && (prev_q == '1) && (count == '0);
    wrap_down_d = checking && !crst_q && !sw_q && (prev_q == '0) && (count == '1);

    if (mismatch_d && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end

    unique case (state_q)
      ST_INIT:  state_d = ST_TRACK;
      ST_TRACK: if (mismatch_d && (err_q != '1) && (err_d == ERR_W'(FAULT_LIMIT))) begin
                  state_d = ST_FAULT;
                end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      prev_q      <= '0;
      sw_q        <= 1'b0;
      crst_q      <= 1'b0;
      expected_q  <= '0;
      mismatch_q  <= 1'b0;
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
      err_q       <= '0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= count;
      sw_q        <= up_down_sw;
      crst_q      <= cnt_reset;
      expected_q  <= expected_d;
      mismatch_q  <= mismatch_d;
      wrap_up_q   <= wrap_up_d;
      wrap_down_q <= wrap_down_d;
      err_q       <= err_d;
      locked_q    <= checking;
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign expected  = expected_q;
  assign mismatch  = mismatch_q;
  assign wrap_up   = wrap_up_q;
  assign wrap_down = wrap_down_q;
  assign err_count = err_q;
  assign locked    = locked_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_up_down_count_checker.sv
// Directed bench for up_down_count_checker; the bench plays the observed counter
// by driving count values and checks the registered checker outputs.
module tb_up_down_count_checker;

  logic       clk;
  logic       reset;
  logic       cnt_reset;
  logic       up_down_sw;
  logic [3:0] count;
  logic [3:0] expected;
  logic       mismatch;
  logic       wrap_up;
  logic       wrap_down;
  logic [7:0] err_count;
  logic       locked;
  logic       fault;

  int n_cmp = 0;
  int n_bad = 0;

  up_down_count_checker #(.WIDTH(4), .ERR_W(8), .FAULT_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_reset  (cnt_reset),
    .up_down_sw (up_down_sw),
    .count      (count),
    .expected   (expected),
    .mismatch   (mismatch),
    .wrap_up    (wrap_up),
    .wrap_down  (wrap_down),
    .err_count  (err_count),
    .locked     (locked),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of counter output, then step past the next edge.
  task automatic drive(input logic cr, input logic sw, input logic [3:0] c);
    cnt_reset  = cr;
    up_down_sw = sw;
    count      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 4'd0);
    drive(1'b1, 1'b1, 4'd0);
    n_cmp++; if (expected !== 4'd0)  begin n_bad++; $display("FAIL rst_expected got %0d want 0", expected); end
    n_cmp++; if (mismatch !== 1'b0)  begin n_bad++; $display("FAIL rst_mismatch got %b want 0", mismatch); end
    n_cmp++; if (wrap_up !== 1'b0)   begin n_bad++; $display("FAIL rst_wrap_up got %b want 0", wrap_up); end
    n_cmp++; if (wrap_down !== 1'b0) begin n_bad++; $display("FAIL rst_wrap_down got %b want 0", wrap_down); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL rst_err got %0d want 0", err_count); end
    n_cmp++; if (locked !== 1'b0)    begin n_bad++; $display("FAIL rst_locked got %b want 0", locked); end
    n_cmp++; if (fault !== 1'b0)     begin n_bad++; $display("FAIL rst_fault got %b want 0", fault); end
    reset = 1'b0;
    drive(1'b1, 1'b1, 4'd0);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_edge1 got %b want 0", locked); end
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 4'd0);
      n_cmp++; if (locked !== 1'b1)    begin n_bad++; $display("FAIL lock_held[%0d] got %b want 1", i, locked); end
      n_cmp++; if (mismatch !== 1'b0)  begin n_bad++; $display("FAIL crst_mismatch[%0d] got %b want 0", i, mismatch); end
      n_cmp++; if (expected !== 4'd0)  begin n_bad++; $display("FAIL crst_expected[%0d] got %0d want 0", i, expected); end
      n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL crst_err[%0d] got %0d want 0", i, err_count); end
    end
  endtask

  task automatic test_count_up();
    logic [3:0] c;
    int wraps;
    c = 4'd0;
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, c);
      if (wrap_up === 1'b1) wraps++;
      n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL up_mismatch[%0d] got %b want 0", i, mismatch); end
      n_cmp++; if (expected !== c)    begin n_bad++; $display("FAIL up_expected[%0d] got %0d want %0d", i, expected, c); end
      n_cmp++; if (wrap_up !== (i == 16)) begin n_bad++; $display("FAIL up_wrap[%0d] got %b want %b", i, wrap_up, (i == 16)); end
      c = c + 4'd1;
    end
    n_cmp++; if (wraps != 1) begin n_bad++; $display("FAIL up_wrap_count got %0d want 1", wraps); end
  endtask

  task automatic test_count_down();
    logic [3:0] seq [6];
    seq = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd15};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, seq[i]);
      n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL dn_mismatch[%0d] got %b want 0", i, mismatch); end
      n_cmp++; if (expected !== seq[i]) begin n_bad++; $display("FAIL dn_expected[%0d] got %0d want %0d", i, expected, seq[i]); end
      n_cmp++; if (wrap_down !== (i == 5)) begin n_bad++; $display("FAIL dn_wrap[%0d] got %b want %b", i, wrap_down, (i == 5)); end
    end
  endtask

  task automatic test_skip();
    drive(1'b1, 1'b1, 4'd14);
    drive(1'b0, 1'b1, 4'd0);
    n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL skip_crst_release got %b want 0", mismatch); end
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b1, 4'(i));
      n_cmp++; if (mismatch !== 1'b0) begin n_bad++; $display("FAIL skip_pre[%0d] got %b want 0", i, mismatch); end
    end
    drive(1'b0, 1'b1, 4'd7);
    n_cmp++; if (mismatch !== 1'b1)  begin n_bad++; $display("FAIL skip_mismatch got %b want 1", mismatch); end
    n_cmp++; if (expected !== 4'd6)  begin n_bad++; $display("FAIL skip_expected got %0d want 6", expected); end
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL skip_err got %0d want 1", err_count); end
    drive(1'b0, 1'b1, 4'd8);
    n_cmp++; if (mismatch !== 1'b0)  begin n_bad++; $display("FAIL skip_recover got %b want 0", mismatch); end
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL skip_err_hold got %0d want 1", err_count); end
  endtask

  task automatic test_fault();
    logic [3:0] seq [8];
    logic [7:0] e_err [8];
    logic       e_mis [8];
    seq   = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd7, 4'd9, 4'd10, 4'd12};
    e_err = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4};
    e_mis = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    reset = 1'b1;
    drive(1'b0, 1'b1, 4'd0);
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL flt_pre_err got %0d want 0", err_count); end
    reset = 1'b0;
    drive(1'b1, 1'b1, 4'd0);
    drive(1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, seq[i]);
      n_cmp++; if (mismatch !== e_mis[i])  begin n_bad++; $display("FAIL flt_mismatch[%0d] got %b want %b", i, mismatch, e_mis[i]); end
      n_cmp++; if (err_count !== e_err[i]) begin n_bad++; $display("FAIL flt_err[%0d] got %0d want %0d", i, err_count, e_err[i]); end
      n_cmp++; if (fault !== (i == 7))     begin n_bad++; $display("FAIL flt_fault[%0d] got %b want %b", i, fault, (i == 7)); end
    end
    drive(1'b1, 1'b1, 4'd13);
    drive(1'b0, 1'b1, 4'd0);
    n_cmp++; if (mismatch !== 1'b0)  begin n_bad++; $display("FAIL flt_crst_mismatch got %b want 0", mismatch); end
    n_cmp++; if (fault !== 1'b1)     begin n_bad++; $display("FAIL flt_sticky got %b want 1", fault); end
    n_cmp++; if (err_count !== 8'd4) begin n_bad++; $display("FAIL flt_err_kept got %0d want 4", err_count); end
    n_cmp++; if (locked !== 1'b1)    begin n_bad++; $display("FAIL flt_locked got %b want 1", locked); end
    reset = 1'b1;
    drive(1'b0, 1'b1, 4'd1);
    n_cmp++; if (fault !== 1'b0)     begin n_bad++; $display("FAIL flt_clear got %b want 0", fault); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL flt_err_clear got %0d want 0", err_count); end
  endtask

  task automatic test_saturate();
    int want;
    reset = 1'b0;
    drive(1'b1, 1'b1, 4'd0);
    drive(1'b0, 1'b1, 4'd0);
    for (int i = 1; i <= 300; i++) begin
      drive(1'b0, 1'b1, 4'd5);
      want = (i > 255) ? 255 : i;
      n_cmp++; if (err_count !== 8'(want)) begin n_bad++; $display("FAIL sat_err[%0d] got %0d want %0d", i, err_count, want); end
      n_cmp++; if (mismatch !== 1'b1) begin n_bad++; $display("FAIL sat_mismatch[%0d] got %b want 1", i, mismatch); end
    end
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL sat_fault got %b want 1", fault); end
    reset = 1'b1;
    drive(1'b0, 1'b1, 4'd5);
    n_cmp++; if (expected !== 4'd0)  begin n_bad++; $display("FAIL mid_expected got %0d want 0", expected); end
    n_cmp++; if (mismatch !== 1'b0)  begin n_bad++; $display("FAIL mid_mismatch got %b want 0", mismatch); end
    n_cmp++; if (wrap_up !== 1'b0)   begin n_bad++; $display("FAIL mid_wrap_up got %b want 0", wrap_up); end
    n_cmp++; if (wrap_down !== 1'b0) begin n_bad++; $display("FAIL mid_wrap_down got %b want 0", wrap_down); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL mid_err got %0d want 0", err_count); end
    n_cmp++; if (locked !== 1'b0)    begin n_bad++; $display("FAIL mid_locked got %b want 0", locked); end
    n_cmp++; if (fault !== 1'b0)     begin n_bad++; $display("FAIL mid_fault got %b want 0", fault); end
  endtask

  task automatic test_back_to_back();
    logic       crs [5];
    logic       sws [5];
    logic [3:0] cs  [5];
    logic       e_wu [5];
    logic       e_wd [5];
    crs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    sws  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    cs   = '{4'd0, 4'd15, 4'd0, 4'd15, 4'd0};
    e_wu = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    e_wd = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    reset = 1'b0;
    drive(1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 5; i++) begin
      drive(crs[i], sws[i], cs[i]);
      n_cmp++; if (mismatch !== 1'b0)   begin n_bad++; $display("FAIL b2b_mismatch[%0d] got %b want 0", i, mismatch); end
      n_cmp++; if (wrap_up !== e_wu[i]) begin n_bad++; $display("FAIL b2b_wrap_up[%0d] got %b want %b", i, wrap_up, e_wu[i]); end
      n_cmp++; if (wrap_down !== e_wd[i]) begin n_bad++; $display("FAIL b2b_wrap_down[%0d] got %b want %b", i, wrap_down, e_wd[i]); end
    end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL b2b_err got %0d want 0", err_count); end
  endtask

  initial begin
    reset      = 1'b1;
    cnt_reset  = 1'b1;
    up_down_sw = 1'b1;
    count      = 4'd0;
    test_reset();
    test_count_up();
    test_count_down();
    test_skip();
    test_fault();
    test_saturate();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
